rx_frame_filter: RTL and testbench

- Sits directly upstream of the receive byte buffer and consumes the tri-mode Ethernet MAC RX AXI-Stream (8-bit, no tready).
- Strips the 14-byte Ethernet header and accepts a frame only if the destination MAC matches cfg_mac_addr (or broadcast, if enabled) and the EtherType equals ETHERTYPE.
- Writes accepted payload bytes into the buffer through its valid/full interface.
- Reports per-frame status and saturating statistics so the consumer can discard bad or truncated payloads.

---
 rtl/rx_pkg.sv | 36 +++
 rtl/rx_frame_filter_sat_counter.sv | 29 ++
 rtl/rx_frame_filter.sv | 231 +++++++++++++++++++++++
 tb/tb_rx_frame_filter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_pkg
// Purpose  : Shared types, constants and header-match helper for the RX
//            frame filter.
// Revision : 1.0 - initial release
// ============================================================================
package rx_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        HDR       = 2'd1,
        PAYLOAD   = 2'd2,
        DISCARD   = 2'd3
    } rx_state_t;

    localparam int          HDR_BYTES = 14;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic        ok;
        logic [15:0] len;
    } frame_status_t;

    function automatic logic hdr_match(
        input logic [47:0] dst,
        input logic [47:0] mac,
        input logic [15:0] etype,
        input logic [15:0] want,
        input logic        bcast_en
    );
        return ((dst == mac) || (bcast_en && (dst == BCAST_MAC))) && (etype == want);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_filter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : rx_sat_counter
// Purpose  : Increment-only counter that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module rx_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rx_frame_filter.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_filter
// Purpose  : Strips the Ethernet header, filters on destination MAC and
//            EtherType, and writes accepted payload into the RX byte buffer.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_filter
    import rx_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int          MAX_PAYLOAD  = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_axis_tdata,
    input  logic        rx_axis_tvalid,
    input  logic        rx_axis_tlast,
    input  logic        rx_axis_tuser,
    input  logic [47:0] cfg_mac_addr,
    input  logic        brx_full,
    output logic        brx_valid,
    output logic [7:0]  brx_data,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_len,
    output logic [15:0] cnt_accepted,
    output logic [15:0] cnt_filtered,
    output logic [15:0] cnt_errored
);

    localparam logic [3:0]  c_last_hdr_idx = 4'(HDR_BYTES - 1);
    localparam logic [15:0] c_max_payload  = 16'(MAX_PAYLOAD);

    rx_state_t     r_state;
    logic [3:0]    r_hdr_idx;
    logic [47:0]   r_dst;
    logic [7:0]    r_type_hi;
    logic [15:0]   r_pay_cnt;
    logic          r_overflow;
    logic          r_oversize;
    logic [15:0]   r_wr_len;
    logic          r_brx_valid;
    logic [7:0]    r_brx_data;

    // Latched copy of the terminated frame so the next frame can start at once
    logic          r_rep_pend;
    logic          r_rep_acc;
    logic          r_rep_tuser;
    logic          r_rep_ovs;
    logic          r_rep_ovf;

    logic          r_frame_done;
    logic          r_frame_ok;
    logic [15:0]   r_frame_len;

    logic          w_ovf_cur;
    logic          w_over_max;
    logic          w_write;
    logic          w_hdr_pass;
    logic          w_last_landed;
    logic          w_fin_ovf;
    frame_status_t w_status;
    logic          w_inc_acc;
    logic          w_inc_flt;
    logic          w_inc_err;

    // While a report is pending, the strobe on the bus is the previous frame's last byte
    assign w_ovf_cur     = r_brx_valid & brx_full & ~r_rep_pend;
    assign w_over_max    = (r_pay_cnt >= c_max_payload);
    assign w_write       = rx_axis_tvalid && (r_state == PAYLOAD) && !r_overflow
                           && !w_ovf_cur && !w_over_max;
    assign w_hdr_pass    = hdr_match(r_dst, cfg_mac_addr, {r_type_hi, rx_axis_tdata},
                                     ETHERTYPE, ACCEPT_BCAST);

    assign w_last_landed = r_brx_valid & ~brx_full;
    assign w_fin_ovf     = r_rep_ovf | (r_brx_valid & brx_full);
    assign w_status.ok   = r_rep_acc & ~r_rep_tuser & ~w_fin_ovf & ~r_rep_ovs;
    assign w_status.len  = r_rep_acc ? (r_wr_len + {15'd0, w_last_landed}) : 16'd0;

    assign w_inc_acc     = r_rep_pend & w_status.ok;
    assign w_inc_flt     = r_rep_pend & ~r_rep_acc;
    assign w_inc_err     = r_rep_pend & r_rep_acc & ~w_status.ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_IDLE;
            r_hdr_idx   <= '0;
            r_dst       <= '0;
            r_type_hi   <= '0;
            r_pay_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_oversize  <= 1'b0;
            r_wr_len    <= '0;
            r_brx_valid <= 1'b0;
            r_brx_data  <= '0;
            r_rep_pend  <= 1'b0;
            r_rep_acc   <= 1'b0;
            r_rep_tuser <= 1'b0;
            r_rep_ovs   <= 1'b0;
            r_rep_ovf   <= 1'b0;
        end else begin
            r_brx_valid <= w_write;
            if (w_write) begin
                r_brx_data <= rx_axis_tdata;
            end
            r_rep_pend <= 1'b0;
            if (w_ovf_cur) begin
                r_overflow <= 1'b1;
            end
            if (r_rep_pend) begin
                r_wr_len <= '0;
            end else if (w_last_landed) begin
                r_wr_len <= r_wr_len + 16'd1;
            end

            case (r_state)
                WAIT_IDLE: begin
                    if (!rx_axis_tvalid) begin
                        r_state   <= HDR;
                        r_hdr_idx <= '0;
                    end
                end
                HDR: begin
                    if (rx_axis_tvalid) begin
                        if (rx_axis_tlast) begin
                            r_hdr_idx   <= '0;
                            r_rep_pend  <= 1'b1;
                            r_rep_acc   <= 1'b0;
                            r_rep_tuser <= 1'b0;
                            r_rep_ovs   <= 1'b0;
                            r_rep_ovf   <= 1'b0;
                        end else if (r_hdr_idx == c_last_hdr_idx) begin
                            r_hdr_idx  <= '0;
                            r_pay_cnt  <= '0;
                            r_overflow <= 1'b0;
                            r_oversize <= 1'b0;
                            r_state    <= w_hdr_pass ? PAYLOAD : DISCARD;
                        end else begin
                            if (r_hdr_idx < 4'd6) begin
                                r_dst <= {r_dst[39:0], rx_axis_tdata};
                            end
                            if (r_hdr_idx == 4'd12) begin
                                r_type_hi <= rx_axis_tdata;
                            end
                            r_hdr_idx <= r_hdr_idx + 4'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_axis_tvalid) begin
                        if (r_pay_cnt != 16'hFFFF) begin
                            r_pay_cnt <= r_pay_cnt + 16'd1;
                        end
                        if (w_over_max) begin
                            r_oversize <= 1'b1;
                        end
                        if (rx_axis_tlast) begin
                            r_rep_pend  <= 1'b1;
                            r_rep_acc   <= 1'b1;
                            r_rep_tuser <= rx_axis_tuser;
                            r_rep_ovs   <= r_oversize | w_over_max;
                            r_rep_ovf   <= r_overflow | w_ovf_cur;
                            r_overflow  <= 1'b0;
                            r_oversize  <= 1'b0;
                            r_hdr_idx   <= '0;
                            r_state     <= HDR;
                        end
                    end
                end
                DISCARD: begin
                    if (rx_axis_tvalid && rx_axis_tlast) begin
                        r_rep_pend  <= 1'b1;
                        r_rep_acc   <= 1'b0;
                        r_rep_tuser <= 1'b0;
                        r_rep_ovs   <= 1'b0;
                        r_rep_ovf   <= 1'b0;
                        r_hdr_idx   <= '0;
                        r_state     <= HDR;
                    end
                end
                default: r_state <= WAIT_IDLE;
            endcase
        end
    end

    // Final status is resolved one cycle after tlast, once the last strobe met brx_full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_len  <= '0;
        end else begin
            r_frame_done <= r_rep_pend;
            r_frame_ok   <= r_rep_pend & w_status.ok;
            if (r_rep_pend) begin
                r_frame_len <= w_status.len;
            end
        end
    end

    rx_sat_counter #(.WIDTH(16)) u_cnt_accepted (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_acc),
        .count (cnt_accepted)
    );

    rx_sat_counter #(.WIDTH(16)) u_cnt_filtered (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_flt),
        .count (cnt_filtered)
    );

    rx_sat_counter #(.WIDTH(16)) u_cnt_errored (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_err),
        .count (cnt_errored)
    );

    assign brx_valid  = r_brx_valid;
    assign brx_data   = r_brx_data;
    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;
    assign frame_len  = r_frame_len;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_filter
// Purpose  : Frame-level reference model driving a per-cycle expectation table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_frame_filter;

    localparam logic [47:0] c_mac   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] c_bcast = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] c_etype = 16'h88B5;
    localparam int          c_maxp  = 1500;
    localparam int          c_nc    = 16000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_axis_tdata = '0;
    logic        rx_axis_tvalid = 1'b0;
    logic        rx_axis_tlast = 1'b0;
    logic        rx_axis_tuser = 1'b0;
    logic        brx_full = 1'b0;
    logic        brx_valid, frame_done, frame_ok;
    logic [7:0]  brx_data;
    logic [15:0] frame_len, cnt_accepted, cnt_filtered, cnt_errored;

    always #5 clk = ~clk;

    rx_frame_filter dut (
        .clk            (clk),
        .rst            (rst),
        .rx_axis_tdata  (rx_axis_tdata),
        .rx_axis_tvalid (rx_axis_tvalid),
        .rx_axis_tlast  (rx_axis_tlast),
        .rx_axis_tuser  (rx_axis_tuser),
        .cfg_mac_addr   (c_mac),
        .brx_full       (brx_full),
        .brx_valid      (brx_valid),
        .brx_data       (brx_data),
        .frame_done     (frame_done),
        .frame_ok       (frame_ok),
        .frame_len      (frame_len),
        .cnt_accepted   (cnt_accepted),
        .cnt_filtered   (cnt_filtered),
        .cnt_errored    (cnt_errored)
    );

    // Stimulus and expectation tables indexed by cycle
    logic        s_tv [c_nc];
    logic [7:0]  s_td [c_nc];
    logic        s_tl [c_nc];
    logic        s_tu [c_nc];
    logic        s_full [c_nc];
    logic        e_bv [c_nc];
    logic [7:0]  e_bd [c_nc];
    logic        e_done [c_nc];
    logic        e_ok [c_nc];
    logic [15:0] e_len [c_nc];
    int          e_kind [c_nc];
    logic [15:0] e_acc [c_nc];
    logic [15:0] e_flt [c_nc];
    logic [15:0] e_err [c_nc];

    int n_cyc, snap_c;
    int base_acc, base_flt, base_err;
    int fin_acc, fin_flt, fin_err;
    int passed, total;
    logic rep_ok_q [$];
    int   rep_len_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < c_nc; i++) begin
            s_tv[i] = 1'b0; s_td[i] = '0; s_tl[i] = 1'b0; s_tu[i] = 1'b0; s_full[i] = 1'b0;
            e_bv[i] = 1'b0; e_bd[i] = '0; e_done[i] = 1'b0; e_ok[i] = 1'b0; e_len[i] = '0;
            e_kind[i] = -1; e_acc[i] = '0; e_flt[i] = '0; e_err[i] = '0;
        end
        n_cyc = 0;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_tv[n_cyc] = 1'b0;
            s_td[n_cyc] = 8'($urandom);
            s_tl[n_cyc] = 1'($urandom);
            s_tu[n_cyc] = 1'($urandom);
            n_cyc++;
        end
    endtask

    // Bytes the filter must ignore: a matching header followed by random data
    task automatic add_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            if (i < 6)        b = c_mac[47-8*i -: 8];
            else if (i == 12) b = c_etype[15:8];
            else if (i == 13) b = c_etype[7:0];
            else              b = 8'($urandom);
            s_tv[n_cyc] = 1'b1; s_td[n_cyc] = b; s_tl[n_cyc] = (i == n - 1); s_tu[n_cyc] = 1'b0;
            n_cyc++;
        end
    endtask

    // One frame: payload written unless overflowed or oversize; full_at = write number stalled by brx_full
    task automatic add_frame(input logic [47:0] dst, input logic [15:0] et, input int plen,
                             input bit tuser, input int full_at, input int runt_len,
                             output int done_c);
        logic [7:0] b [$];
        int  len_f, s, nwr, nstb, wlen;
        bit  acc, ovf, ok;
        for (int i = 0; i < 6; i++) b.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        b.push_back(et[15:8]);
        b.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) b.push_back(8'($urandom));
        len_f = (runt_len > 0) ? runt_len : 14 + plen;
        s = n_cyc;
        for (int i = 0; i < len_f; i++) begin
            s_tv[s+i] = 1'b1;
            s_td[s+i] = b[i];
            s_tl[s+i] = (i == len_f - 1);
            s_tu[s+i] = (i == len_f - 1) ? tuser : 1'($urandom);
        end
        n_cyc = s + len_f;
        acc = (len_f >= 15) && ((dst == c_mac) || (dst == c_bcast)) && (et == c_etype);
        wlen = 0; ovf = 1'b0;
        if (acc) begin
            nwr = (plen < c_maxp) ? plen : c_maxp;
            if (full_at > 0 && full_at <= nwr) begin
                nstb = full_at; ovf = 1'b1; wlen = full_at - 1;
            end else begin
                nstb = nwr; wlen = nwr;
            end
            for (int k = 0; k < nstb; k++) begin
                e_bv[s+15+k] = 1'b1;
                e_bd[s+15+k] = b[14+k];
                if (ovf && k == full_at - 1) s_full[s+15+k] = 1'b1;
            end
        end
        ok = acc && !tuser && !ovf && (plen <= c_maxp);
        done_c = s + len_f + 1;
        e_done[done_c] = 1'b1;
        e_ok[done_c]   = ok;
        e_len[done_c]  = 16'(wlen);
        e_kind[done_c] = !acc ? 0 : (ok ? 1 : 2);
    endtask

    task automatic finalize();
        int a, f, e;
        a = base_acc; f = base_flt; e = base_err;
        for (int c = 0; c < n_cyc; c++) begin
            if (e_kind[c] == 0) f++;
            if (e_kind[c] == 1) a++;
            if (e_kind[c] == 2) e++;
            e_acc[c] = 16'(a); e_flt[c] = 16'(f); e_err[c] = 16'(e);
            if (!e_bv[c] && !s_full[c]) s_full[c] = ($urandom_range(0, 3) == 0);
        end
        fin_acc = a; fin_flt = f; fin_err = e;
    endtask

    task automatic check_cycle(input int c);
        chk("brx_valid", brx_valid, e_bv[c]);
        if (e_bv[c] && brx_valid) chk("brx_data", brx_data, e_bd[c]);
        chk("frame_done", frame_done, e_done[c]);
        if (frame_done) begin
            rep_ok_q.push_back(frame_ok);
            rep_len_q.push_back(int'(frame_len));
        end
        if (e_done[c]) begin
            chk("frame_ok", frame_ok, e_ok[c]);
            chk("frame_len", frame_len, e_len[c]);
        end
        chk("cnt_accepted", cnt_accepted, e_acc[c]);
        chk("cnt_filtered", cnt_filtered, e_flt[c]);
        chk("cnt_errored", cnt_errored, e_err[c]);
        if (c == snap_c) begin
            chk("directed cnt_accepted", cnt_accepted, 3);
            chk("directed cnt_filtered", cnt_filtered, 3);
            chk("directed cnt_errored", cnt_errored, 2);
        end
    endtask

    task automatic run_sched(input int limit, input bit wait_first);
        for (int c = 0; c < limit; c++) begin
            if (c > 0 || wait_first) @(negedge clk);
            check_cycle(c);
            rx_axis_tvalid = s_tv[c];
            rx_axis_tdata  = s_td[c];
            rx_axis_tlast  = s_tl[c];
            rx_axis_tuser  = s_tu[c];
            brx_full       = s_full[c];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " brx_valid"}, brx_valid, 0);
        chk({tag, " brx_data"}, brx_data, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        chk({tag, " frame_ok"}, frame_ok, 0);
        chk({tag, " frame_len"}, frame_len, 0);
        chk({tag, " cnt_accepted"}, cnt_accepted, 0);
        chk({tag, " cnt_filtered"}, cnt_filtered, 0);
        chk({tag, " cnt_errored"}, cnt_errored, 0);
    endtask

    initial begin
        int d, q0, sel, plen, fa, rl;
        logic [47:0] dst;
        logic [15:0] et;
        int lit_len [8] = '{46, 0, 20, 0, 0, 39, 30, 50};
        logic lit_ok [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        passed = 0; total = 0;

        #1 rst = 1'b1;
        #1 chk_all_zero("reset");

        // Phase 1: directed frames then randomized traffic, starting mid-frame
        clear_sched();
        base_acc = 0; base_flt = 0; base_err = 0;
        add_junk(30);
        add_idle(2);
        add_frame(c_mac, c_etype, 46, 1'b0, 0, 0, d);              add_idle(3);
        add_frame(48'h02_00_00_00_00_02, c_etype, 46, 1'b0, 0, 0, d); add_idle(2);
        add_frame(c_bcast, c_etype, 20, 1'b0, 0, 0, d);            add_idle(1);
        add_frame(c_mac, 16'h0800, 30, 1'b0, 0, 0, d);             add_idle(1);
        add_frame(c_mac, c_etype, 0, 1'b0, 0, 10, d);              add_idle(1);
        add_frame(c_mac, c_etype, 100, 1'b0, 40, 0, d);            add_idle(2);
        add_frame(c_mac, c_etype, 30, 1'b1, 0, 0, d);
        add_frame(c_mac, c_etype, 50, 1'b0, 0, 0, d);
        snap_c = d;
        add_idle(3);
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0, 1:    dst = c_mac;
                2:       dst = c_bcast;
                3:       dst = c_mac ^ (48'h1 << $urandom_range(0, 47));
                default: dst = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
            endcase
            sel = $urandom_range(0, 3);
            et = (sel < 2) ? c_etype : ((sel == 2) ? 16'h0800 : 16'h88B4);
            plen = $urandom_range(0, 120);
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, plen + 2) : 0;
            rl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 14) : 0;
            add_frame(dst, et, plen, ($urandom_range(0, 4) == 0), fa, rl, d);
            add_idle($urandom_range(0, 3));
        end
        add_frame(c_mac, c_etype, 1500, 1'b0, 0, 0, d); add_idle(1);
        add_frame(c_mac, c_etype, 1501, 1'b0, 0, 0, d); add_idle(4);
        finalize();
        @(negedge clk);
        rst = 1'b0;
        run_sched(n_cyc, 1'b0);

        q0 = rep_ok_q.size();
        chk("phase1 report count", q0, 40);
        for (int i = 0; i < 8; i++) begin
            if (i < q0) begin
                chk($sformatf("directed%0d frame_ok", i), rep_ok_q[i], lit_ok[i]);
                chk($sformatf("directed%0d frame_len", i), rep_len_q[i], lit_len[i]);
            end
        end

        // Phase 2: reset asserted mid-payload while tvalid stays high
        clear_sched();
        base_acc = fin_acc; base_flt = fin_flt; base_err = fin_err;
        snap_c = -1;
        add_idle(3);
        add_frame(c_mac, c_etype, 60, 1'b0, 0, 0, d);
        add_idle(4);
        finalize();
        run_sched(38, 1'b1);
        chk("pre-reset brx_valid", brx_valid, 1);
        #3 rst = 1'b1;
        #1 chk_all_zero("async reset");

        clear_sched();
        base_acc = 0; base_flt = 0; base_err = 0;
        add_junk(25);
        add_idle(2);
        add_frame(c_mac, c_etype, 33, 1'b0, 0, 0, d);   add_idle(2);
        add_frame(c_bcast, c_etype, 12, 1'b0, 0, 0, d); add_idle(4);
        finalize();
        @(negedge clk);
        rst = 1'b0;
        run_sched(n_cyc, 1'b0);

        chk("post-reset report count", rep_ok_q.size(), q0 + 2);
        if (rep_ok_q.size() > q0) begin
            chk("post-reset frame_ok", rep_ok_q[q0], 1);
            chk("post-reset frame_len", rep_len_q[q0], 33);
        end
        chk("final cnt_accepted", cnt_accepted, 2);
        chk("final cnt_filtered", cnt_filtered, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
